// File: rtl/multiplier_booth_if.sv
// Operand/product bundle for the radix-4 Booth multiplier.
// The master drives the enable and operands, and the slave returns the registered product.
interface multiplier_booth_if #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = WIDTH_A + WIDTH_B
);
    logic                 pip_en;
    logic [WIDTH_A-1:0]   A;
    logic [WIDTH_B-1:0]   B;
    logic [WIDTH_MUL-1:0] OUT;

    modport master (output pip_en, output A, output B, input OUT);
    modport slave  (input pip_en, input A, input B, output OUT);
endinterface

// File: rtl/multiplier_booth.sv
// Radix-4 Booth multiplier: recoded partial products, a carry-save tree with optional
// pipeline cuts, a final carry-propagate adder and a registered product.
module multiplier_booth #(
    parameter int WIDTH_A     = 16,
    parameter int WIDTH_B     = 16,
    parameter int WIDTH_MUL   = WIDTH_A + WIDTH_B,
    parameter int SIGNED      = 1,
    parameter int STAGE       = 0,
    parameter int APPROX_TYPE = 0,
    parameter int APPROX_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    multiplier_booth_if.slave bus
);
    localparam int W   = WIDTH_MUL;
    localparam int ND  = (WIDTH_B + 2) / 2;
    localparam int NR0 = ND + 1;
    localparam int BX  = 2 * ND + 1;

    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int num_levels(input int n);
        int r;
        int c;
        r = n;
        c = 0;
        while (r > 2) begin
            r = next_rows(r);
            c = c + 1;
        end
        return c;
    endfunction

    function automatic int rows_at(input int n, input int l);
        int r;
        r = n;
        for (int k = 0; k < l; k++) begin
            r = next_rows(r);
        end
        return r;
    endfunction

    // Spread the STAGE register cuts evenly over the tree levels.
    function automatic bit is_cut(input int l, input int nl, input int st);
        bit c;
        c = 1'b0;
        for (int j = 1; j <= st; j++) begin
            if ((j * nl) / (st + 1) == l + 1) begin
                c = 1'b1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    function automatic int num_cuts(input int nl, input int st);
        int c;
        c = 0;
        for (int l = 0; l < nl; l++) begin
            if (is_cut(l, nl, st)) begin
                c = c + 1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    localparam int NL    = num_levels(NR0);
    localparam int NCUT  = num_cuts(NL, STAGE);
    localparam int EXTRA = STAGE - NCUT;

    logic          sgn_s;
    logic [W-1:0]  a_w_s;
    logic [BX-1:0] b_pad_s;
    logic [W-1:0]  mask_s;
    logic [W-1:0]  corr_s;
    logic [W-1:0]  pp_s [NR0];
    logic [W-1:0]  cpa_s;
    logic [W-1:0]  fin_s;
    logic [W-1:0]  out_q;

    assign sgn_s   = (SIGNED != 0) ? 1'b1 : 1'b0;
    assign a_w_s   = {{(W - WIDTH_A){bus.A[WIDTH_A-1] & sgn_s}}, bus.A};
    assign b_pad_s = {{(BX - 1 - WIDTH_B){bus.B[WIDTH_B-1] & sgn_s}}, bus.B, 1'b0};

    // Booth recoding: one partial-product row per digit, plus one row holding all +1 corrections.
    always_comb begin
        logic [2:0]   trip;
        logic [W-1:0] mult;
        logic         neg;
        trip   = 3'b000;
        mult   = '0;
        neg    = 1'b0;
        corr_s = '0;
        mask_s = '1;
        for (int k = 0; k < W; k++) begin
            mask_s[k] = (APPROX_TYPE == 1 && k < APPROX_W) ? 1'b0 : 1'b1;
        end
        for (int i = 0; i < ND; i++) begin
            trip = b_pad_s[2*i +: 3];
            case (trip)
                3'b001, 3'b010: begin mult = a_w_s;         neg = 1'b0; end
                3'b011:         begin mult = a_w_s << 1;    neg = 1'b0; end
                3'b100:         begin mult = a_w_s << 1;    neg = 1'b1; end
                3'b101, 3'b110: begin mult = a_w_s;         neg = 1'b1; end
                default:        begin mult = '0;            neg = 1'b0; end
            endcase
            pp_s[i]     = ((neg ? ~mult : mult) << (2 * i)) & mask_s;
            corr_s[2*i] = neg;
        end
        pp_s[ND] = corr_s & mask_s;
    end

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int NIN  = rows_at(NR0, l);
        localparam int NOUT = next_rows(NIN);
        logic [W-1:0] in_s   [NIN];
        logic [W-1:0] rows_d [NOUT];
        logic [W-1:0] out_s  [NOUT];

        if (l == 0) begin : g_src0
            assign in_s = pp_s;
        end else begin : g_srcn
            assign in_s = g_lvl[l-1].out_s;
        end

        // 3:2 compression of each row triple; leftover rows pass through.
        always_comb begin
            for (int r = 0; r < NOUT; r++) begin
                rows_d[r] = '0;
            end
            for (int g = 0; g < NIN / 3; g++) begin
                rows_d[2*g]   = in_s[3*g] ^ in_s[3*g+1] ^ in_s[3*g+2];
                rows_d[2*g+1] = ((in_s[3*g] & in_s[3*g+1]) |
                                 (in_s[3*g] & in_s[3*g+2]) |
                                 (in_s[3*g+1] & in_s[3*g+2])) << 1;
            end
            for (int r = 0; r < NIN % 3; r++) begin
                rows_d[2*(NIN/3)+r] = in_s[3*(NIN/3)+r];
            end
        end

        if (is_cut(l, NL, STAGE)) begin : g_reg
            logic [W-1:0] rows_q [NOUT];
            // Pipeline cut inside the tree, advancing only on enabled cycles.
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    for (int r = 0; r < NOUT; r++) begin
                        rows_q[r] <= '0;
                    end
                end else if (bus.pip_en) begin
                    rows_q <= rows_d;
                end
            end
            assign out_s = rows_q;
        end else begin : g_comb
            assign out_s = rows_d;
        end
    end

    assign cpa_s = g_lvl[NL-1].out_s[0] + g_lvl[NL-1].out_s[1];

    // Stages that found no distinct tree level to sit in are placed after the adder.
    if (EXTRA > 0) begin : g_extra
        logic [W-1:0] dly_q [EXTRA];
        // Post-adder delay chain gated by the pipeline enable.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                for (int k = 0; k < EXTRA; k++) begin
                    dly_q[k] <= '0;
                end
            end else if (bus.pip_en) begin
                dly_q[0] <= cpa_s;
                for (int k = 1; k < EXTRA; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end
        assign fin_s = dly_q[EXTRA-1];
    end else begin : g_noextra
        assign fin_s = cpa_s;
    end

    // Product output register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_q <= '0;
        end else if (bus.pip_en) begin
            out_q <= fin_s;
        end
    end

    assign bus.OUT = out_q;
endmodule

// File: tb/tb_multiplier_booth.sv
// Directed checks of the Booth multiplier in exact, pipelined, unsigned and approximate builds.
module tb_multiplier_booth;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiplier_booth_if #(.WIDTH_A(16), .WIDTH_B(16)) if0 ();
    multiplier_booth_if #(.WIDTH_A(16), .WIDTH_B(16)) if2 ();
    multiplier_booth_if #(.WIDTH_A(16), .WIDTH_B(16)) ifu ();
    multiplier_booth_if #(.WIDTH_A(16), .WIDTH_B(16)) ifa ();

    multiplier_booth #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1), .STAGE(0),
                       .APPROX_TYPE(0), .APPROX_W(8))
        u_exact (.clk(clk), .rst_n(rst_n), .bus(if0));
    multiplier_booth #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1), .STAGE(2),
                       .APPROX_TYPE(0), .APPROX_W(8))
        u_stage2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    multiplier_booth #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(0), .STAGE(0),
                       .APPROX_TYPE(0), .APPROX_W(8))
        u_unsigned (.clk(clk), .rst_n(rst_n), .bus(ifu));
    multiplier_booth #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1), .STAGE(0),
                       .APPROX_TYPE(1), .APPROX_W(8))
        u_approx (.clk(clk), .rst_n(rst_n), .bus(ifa));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic mul0(input logic [15:0] a, input logic [15:0] b);
        if0.A      = a;
        if0.B      = b;
        if0.pip_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [15:0]        a2   [5];
    logic [15:0]        b2   [5];
    logic [31:0]        exp2 [5];
    logic [15:0]        ra;
    logic [15:0]        rb;
    logic signed [31:0] prod;
    longint             diff;

    initial begin
        rst_n      = 1'b1;
        if0.pip_en = 1'b0; if0.A = 16'h0000; if0.B = 16'h0000;
        if2.pip_en = 1'b0; if2.A = 16'h0000; if2.B = 16'h0000;
        ifu.pip_en = 1'b0; ifu.A = 16'h0000; ifu.B = 16'h0000;
        ifa.pip_en = 1'b0; ifa.A = 16'h0000; ifa.B = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_exact",    if0.OUT, 32'h0000_0000);
        check("reset_stage2",   if2.OUT, 32'h0000_0000);
        check("reset_unsigned", ifu.OUT, 32'h0000_0000);
        check("reset_approx",   ifa.OUT, 32'h0000_0000);
        rst_n = 1'b0;

        mul0(16'h7FFF, 16'h7FFF); check("maxpos_sq",   if0.OUT, 32'h3FFF_0001);
        mul0(16'h8000, 16'h8000); check("maxneg_sq",   if0.OUT, 32'h4000_0000);
        mul0(16'h8000, 16'h8001); check("maxneg_x",    if0.OUT, 32'h3FFF_8000);
        mul0(16'h0400, 16'hFFF0); check("1024_m16",    if0.OUT, 32'hFFFF_C000);
        mul0(16'h0002, 16'hF000); check("2_m4096",     if0.OUT, 32'hFFFF_E000);
        mul0(16'hFFFF, 16'h0001); check("m1_x1",       if0.OUT, 32'hFFFF_FFFF);
        mul0(16'h0003, 16'hFFFD); check("3_m3",        if0.OUT, 32'hFFFF_FFF7);
        mul0(16'h0000, 16'h8000); check("zero_x",      if0.OUT, 32'h0000_0000);
        mul0(16'hAAAA, 16'h5555); check("aaaa_5555",   if0.OUT, 32'hE38E_1C72);

        if0.pip_en = 1'b0;
        if0.A      = 16'h7FFF;
        if0.B      = 16'h7FFF;
        repeat (2) @(posedge clk);
        #1;
        check("hold_pip_en0", if0.OUT, 32'hE38E_1C72);

        if0.pip_en = 1'b1;
        @(posedge clk);
        #1;
        check("before_async_rst", if0.OUT, 32'h3FFF_0001);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst", if0.OUT, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_over_pip_en", if0.OUT, 32'h0000_0000);
        rst_n = 1'b0;
        mul0(16'h7FFF, 16'h7FFF); check("refill", if0.OUT, 32'h3FFF_0001);

        a2[0] = 16'h0003; b2[0] = 16'h0005; exp2[0] = 32'h0000_000F;
        a2[1] = 16'hFFFF; b2[1] = 16'hFFFF; exp2[1] = 32'h0000_0001;
        a2[2] = 16'h7FFF; b2[2] = 16'h8000; exp2[2] = 32'hC000_8000;
        a2[3] = 16'h0100; b2[3] = 16'h0100; exp2[3] = 32'h0001_0000;
        a2[4] = 16'h8000; b2[4] = 16'h8000; exp2[4] = 32'h4000_0000;
        if2.pip_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                if2.A = a2[i];
                if2.B = b2[i];
            end else begin
                if2.A = 16'h0000;
                if2.B = 16'h0000;
            end
            @(posedge clk);
            #1;
            if (i >= 2) begin
                check($sformatf("stage2_p%0d", i - 2), if2.OUT, exp2[i-2]);
            end else begin
                check($sformatf("stage2_fill%0d", i), if2.OUT, 32'h0000_0000);
            end
        end
        if2.pip_en = 1'b0;
        if2.A      = 16'h1234;
        if2.B      = 16'h5678;
        repeat (3) @(posedge clk);
        #1;
        check("stage2_hold", if2.OUT, 32'h4000_0000);

        ifu.pip_en = 1'b1;
        ifu.A = 16'hFFFF; ifu.B = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        check("unsigned_ffff_sq", ifu.OUT, 32'hFFFE_0001);
        ifu.A = 16'h8000; ifu.B = 16'h0002;
        repeat (2) @(posedge clk);
        #1;
        check("unsigned_8000_x2", ifu.OUT, 32'h0001_0000);

        // For 0x7FFF squared only the digit-0 correction bit lands in the dropped columns.
        ifa.pip_en = 1'b1;
        ifa.A = 16'h7FFF; ifa.B = 16'h7FFF;
        repeat (2) @(posedge clk);
        #1;
        check("approx_value",   ifa.OUT, 32'h3FFF_0000);
        check("approx_lowbyte", {24'h000000, ifa.OUT[7:0]}, 32'h0000_0000);
        ifa.A = 16'hAAAA; ifa.B = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        diff = longint'(32'shE38E_1C72) - longint'($signed(ifa.OUT));
        if (diff < 0) diff = -diff;
        check("approx_err_bound", (diff < 64'sd4096) ? 32'd1 : 32'd0, 32'd1);
        check("approx_lowbyte2", {24'h000000, ifa.OUT[7:0]}, 32'h0000_0000);

        for (int n = 0; n < 100; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            prod = 32'($signed(ra)) * 32'($signed(rb));
            if0.A = ra;
            if0.B = rb;
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_%h_%h", n, ra, rb), if0.OUT, prod);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
